// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiplier datapath and its tile sequencer.
package vec_mul_pkg;

  localparam int VM_MATRIX_SIZE = 8;
  localparam int VM_NUM_PE_ROWS = 8;
  localparam int VM_ADDRESSSIZE = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    POP,
    WRL,
    STREAM,
    DRAIN,
    WB,
    DONE
  } vm_state_e;

endpackage

// File: rtl/vec_mul_tile_ctrl_if.sv
// Host/datapath control bundle of the tile sequencer; slave = sequencer side.
interface vec_mul_tile_ctrl_if
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = VM_ADDRESSSIZE,
  parameter int TILE_W      = 4
);
  logic                   start;
  logic                   abort;
  logic [TILE_W-1:0]      num_tiles;
  logic [ADDRESSSIZE-1:0] act_base;
  logic [ADDRESSSIZE-1:0] res_base;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic [ADDRESSSIZE-1:0] sram_address;
  logic                   valid_address;
  logic                   res_write_enable;
  logic [ADDRESSSIZE-1:0] res_address;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, abort, num_tiles, act_base, res_base, fifo_empty,
    output fifo_read_enable, weight_reload, sram_address, valid_address,
           res_write_enable, res_address, busy, done
  );

  modport master (
    output start, abort, num_tiles, act_base, res_base, fifo_empty,
    input  fifo_read_enable, weight_reload, sram_address, valid_address,
           res_write_enable, res_address, busy, done
  );
endinterface

// File: rtl/vec_mul_addr_gen.sv
// Tile address generator: base + t*M + k for the activation and result SRAMs, modulo 2^ADDRESSSIZE.
module vec_mul_addr_gen #(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 8,
  parameter int TILE_W      = 4,
  parameter int CNT_W       = 5
) (
  input  logic [ADDRESSSIZE-1:0] act_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic [TILE_W-1:0]      tile,
  input  logic [CNT_W-1:0]       k,
  output logic [ADDRESSSIZE-1:0] act_addr,
  output logic [ADDRESSSIZE-1:0] res_addr
);
  logic [ADDRESSSIZE-1:0] offset;

  always_comb begin
    offset   = ADDRESSSIZE'(tile) * ADDRESSSIZE'(MATRIX_SIZE) + ADDRESSSIZE'(k);
    act_addr = act_base + offset;
    res_addr = res_base + offset;
  end
endmodule

// File: rtl/vec_mul_tile_ctrl.sv
// Tile sequencer for TOP_vec_mul: weight pop/reload, activation stream, drain, write-back per tile.
// Optional VEC_MUL_CTRL_PERF_EN adds the stall_cnt FIFO-starvation counter output.
module vec_mul_tile_ctrl
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE  = VM_ADDRESSSIZE,
  parameter int MATRIX_SIZE  = VM_MATRIX_SIZE,
  parameter int NUM_PE_ROWS  = VM_NUM_PE_ROWS,
  parameter int DRAIN_CYCLES = MATRIX_SIZE + NUM_PE_ROWS,
  parameter int TILE_W       = 4
) (
  input logic                 clk,
  input logic                 rstn,
  vec_mul_tile_ctrl_if.slave  bus
`ifdef VEC_MUL_CTRL_PERF_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);
  localparam int CNT_MAX = (DRAIN_CYCLES > MATRIX_SIZE) ? DRAIN_CYCLES : MATRIX_SIZE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  vm_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TILE_W-1:0]      tile_q, tile_d;
  logic [TILE_W-1:0]      ntiles_q;
  logic [ADDRESSSIZE-1:0] act_q, res_q;
  logic [ADDRESSSIZE-1:0] act_addr, res_addr;
  logic                   accept;
  logic                   more_tiles;

  assign accept     = (state_q == IDLE) && bus.start && !bus.abort;
  assign more_tiles = ((TILE_W+1)'(tile_q) + (TILE_W+1)'(1)) < {1'b0, ntiles_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
      act_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      if (accept) begin
        ntiles_q <= bus.num_tiles;
        act_q    <= bus.act_base;
        res_q    <= bus.res_base;
      end
    end
  end

  // cnt_q is shared: row index k in STREAM/WB, elapsed cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          tile_d  = '0;
          state_d = (bus.num_tiles == '0) ? DONE : WAIT;
        end
      end
      WAIT:   if (!bus.fifo_empty) state_d = POP;
      POP:    state_d = WRL;
      WRL: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (cnt_q == CNT_W'(MATRIX_SIZE - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        if (cnt_q == CNT_W'(MATRIX_SIZE - 1)) begin
          cnt_d = '0;
          if (more_tiles) begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = WAIT;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  vec_mul_addr_gen #(
    .ADDRESSSIZE (ADDRESSSIZE),
    .MATRIX_SIZE (MATRIX_SIZE),
    .TILE_W      (TILE_W),
    .CNT_W       (CNT_W)
  ) u_addr_gen (
    .act_base (act_q),
    .res_base (res_q),
    .tile     (tile_q),
    .k        (cnt_q),
    .act_addr (act_addr),
    .res_addr (res_addr)
  );

  always_comb begin
    bus.fifo_read_enable = (state_q == POP);
    bus.weight_reload    = (state_q == WRL);
    bus.valid_address    = (state_q == STREAM);
    bus.sram_address     = (state_q == STREAM) ? act_addr : '0;
    bus.res_write_enable = (state_q == WB);
    bus.res_address      = (state_q == WB) ? res_addr : '0;
    bus.busy             = (state_q != IDLE);
    bus.done             = (state_q == DONE);
  end

`ifdef VEC_MUL_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == WAIT) && bus.fifo_empty && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_vec_mul_tile_ctrl.sv
// Directed bench for vec_mul_tile_ctrl against a tile-timeline model; optional VEC_MUL_CTRL_PERF_EN.
module tb_vec_mul_tile_ctrl;
  import vec_mul_pkg::*;

  localparam int AW       = VM_ADDRESSSIZE;
  localparam int M        = VM_MATRIX_SIZE;
  localparam int D        = VM_MATRIX_SIZE + VM_NUM_PE_ROWS;
  localparam int TW       = 4;
  localparam int TILE_LEN = 2 + M + D + M;
  localparam int WB_LO    = 2 + M + D;

  localparam int MD_IDLE = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_RUN  = 2;
  localparam int MD_DONE = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vec_mul_tile_ctrl_if #(.ADDRESSSIZE(AW), .TILE_W(TW)) bus ();

`ifdef VEC_MUL_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  vec_mul_tile_ctrl #(
    .ADDRESSSIZE  (AW),
    .MATRIX_SIZE  (M),
    .NUM_PE_ROWS  (VM_NUM_PE_ROWS),
    .DRAIN_CYCLES (D),
    .TILE_W       (TW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef VEC_MUL_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int s_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: a job is a run of tiles; each tile is a WAIT hold followed by a fixed
  // TILE_LEN-cycle timeline measured from the POP cycle (offset 0).
  int mode = MD_IDLE;
  int off = 0, t = 0, nt = 0, ab = 0, rb = 0, exp_stall = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode = MD_IDLE; off = 0; t = 0; exp_stall = 0;
    end else begin
      if (mode == MD_WAIT && bus.fifo_empty && exp_stall < 65535) exp_stall++;
      if (mode == MD_IDLE && bus.start && !bus.abort) exp_stall = 0;
      if (bus.abort) mode = MD_IDLE;
      else begin
        case (mode)
          MD_IDLE: if (bus.start) begin
            nt = int'(bus.num_tiles); ab = int'(bus.act_base); rb = int'(bus.res_base); t = 0;
            mode = (nt == 0) ? MD_DONE : MD_WAIT;
          end
          MD_WAIT: if (!bus.fifo_empty) begin mode = MD_RUN; off = 0; end
          MD_RUN: begin
            off++;
            if (off == TILE_LEN) begin
              if (t + 1 < nt) begin t++; mode = MD_WAIT; end
              else mode = MD_DONE;
            end
          end
          default: mode = MD_IDLE;
        endcase
      end
    end
  end

  int act_log[$];
  int res_log[$];
  int n_pop = 0, n_done = 0, first_pop = -1, first_we = -1, done_n = -1;

  always @(negedge clk) begin
    bit run, e_val, e_we;
    int e_sa, e_ra;
    run   = (mode == MD_RUN);
    e_val = run && off >= 2 && off < 2 + M;
    e_we  = run && off >= WB_LO && off < WB_LO + M;
    e_sa  = e_val ? ((ab + t * M + off - 2) % (1 << AW)) : 0;
    e_ra  = e_we ? ((rb + t * M + off - WB_LO) % (1 << AW)) : 0;
    chk("busy", bus.busy, mode != MD_IDLE);
    chk("done", bus.done, mode == MD_DONE);
    chk("fifo_read_enable", bus.fifo_read_enable, run && off == 0);
    chk("weight_reload", bus.weight_reload, run && off == 1);
    chk("valid_address", bus.valid_address, e_val);
    chk("sram_address", bus.sram_address, e_sa);
    chk("res_write_enable", bus.res_write_enable, e_we);
    chk("res_address", bus.res_address, e_ra);
`ifdef VEC_MUL_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
    if (bus.valid_address) act_log.push_back(int'(bus.sram_address));
    if (bus.res_write_enable) begin
      res_log.push_back(int'(bus.res_address));
      if (first_we < 0) first_we = cyc - s_cyc;
    end
    if (bus.fifo_read_enable) begin
      n_pop++;
      if (first_pop < 0) first_pop = cyc - s_cyc;
    end
    if (bus.done) begin
      n_done++;
      done_n = cyc - s_cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    act_log.delete(); res_log.delete();
    n_pop = 0; n_done = 0; first_pop = -1; first_we = -1; done_n = -1;
  endtask

  // Returns in cycle n=1 of the job (state just after the accepting edge).
  task automatic start_job(input int ntl, input int a, input int r);
    bus.start = 1'b1;
    bus.num_tiles = TW'(ntl);
    bus.act_base = AW'(a);
    bus.res_base = AW'(r);
    tick();
    s_cyc = cyc - 1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) break;
      tick();
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, bus.busy, 1'b0);
    chk({nm, "_done"}, bus.done, 1'b0);
    chk({nm, "_pop"}, bus.fifo_read_enable, 1'b0);
    chk({nm, "_wrl"}, bus.weight_reload, 1'b0);
    chk({nm, "_valid"}, bus.valid_address, 1'b0);
    chk({nm, "_sram"}, bus.sram_address, 0);
    chk({nm, "_we"}, bus.res_write_enable, 1'b0);
    chk({nm, "_res"}, bus.res_address, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_exp[8];
    wrap_exp = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_tiles = '0;
    bus.act_base = '0; bus.res_base = '0; bus.fifo_empty = 1'b0;
    rstn = 1'b0;
    tick(2);
    chk_quiet("reset");
    rstn = 1'b1;
    tick(2);

    // single tile, bases 0
    clear_log();
    start_job(1, 0, 0);
    wait_idle(200);
    chk("t1_pop_n", first_pop, 2);
    chk("t1_we_n", first_we, 28);
    chk("t1_done_n", done_n, 36);
    chk("t1_nact", act_log.size(), 8);
    chk("t1_nres", res_log.size(), 8);
    for (int i = 0; i < act_log.size(); i++) chk("t1_act", act_log[i], i);
    for (int i = 0; i < res_log.size(); i++) chk("t1_res", res_log[i], i);
    tick(2);

    // three tiles
    clear_log();
    start_job(3, 16, 100);
    wait_idle(400);
    chk("t2_nact", act_log.size(), 24);
    chk("t2_nres", res_log.size(), 24);
    for (int i = 0; i < act_log.size(); i++) chk("t2_act", act_log[i], 16 + i);
    for (int i = 0; i < res_log.size(); i++) chk("t2_res", res_log[i], 100 + i);
    chk("t2_pops", n_pop, 3);
    chk("t2_dones", n_done, 1);
    chk("t2_done_n", done_n, 106);
    tick(2);

    // FIFO empty for the first 5 WAIT cycles
    clear_log();
    bus.fifo_empty = 1'b1;
    start_job(1, 0, 0);
    tick(5);
    chk("t3_no_pop_hold", n_pop, 0);
    bus.fifo_empty = 1'b0;
    wait_idle(200);
    chk("t3_pop_n", first_pop, 7);
    chk("t3_done_n", done_n, 41);
`ifdef VEC_MUL_CTRL_PERF_EN
    chk("t3_stall", stall_cnt, 5);
    tick(3);
    chk("t3_stall_hold", stall_cnt, 5);
`endif
    tick(2);

    // activation address wrap
    clear_log();
    start_job(1, 1020, 0);
    wait_idle(200);
    chk("t4_nact", act_log.size(), 8);
    for (int i = 0; i < act_log.size() && i < 8; i++) chk("t4_act", act_log[i], wrap_exp[i]);
    tick(2);

    // abort during DRAIN, then restart 2 cycles later
    clear_log();
    start_job(1, 0, 0);
    tick(14);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_quiet("t5_abort");
    tick();
    chk("t5_no_done", n_done, 0);
    clear_log();
    start_job(1, 8, 8);
    wait_idle(200);
    chk("t5_done_n", done_n, 36);
    chk("t5_dones", n_done, 1);
    chk("t5_nact", act_log.size(), 8);
    if (act_log.size() > 0) chk("t5_act0", act_log[0], 8);
    tick(2);

    // zero tiles
    clear_log();
    start_job(0, 5, 5);
    chk("t6_done_now", bus.done, 1'b1);
    wait_idle(20);
    chk("t6_done_n", done_n, 1);
    chk("t6_pops", n_pop, 0);
    chk("t6_nact", act_log.size(), 0);
    chk("t6_nres", res_log.size(), 0);
    tick(2);

    // start while busy is ignored
    clear_log();
    start_job(1, 64, 128);
    tick(10);
    bus.start = 1'b1; bus.num_tiles = TW'(2); bus.act_base = AW'(200); bus.res_base = AW'(300);
    tick();
    bus.start = 1'b0;
    wait_idle(200);
    chk("t7_dones", n_done, 1);
    chk("t7_nact", act_log.size(), 8);
    if (act_log.size() > 0) chk("t7_act0", act_log[0], 64);
    if (res_log.size() > 0) chk("t7_res0", res_log[0], 128);
    tick(2);

    // abort and start together in IDLE
    clear_log();
    bus.abort = 1'b1; bus.start = 1'b1; bus.num_tiles = TW'(1);
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("t8_busy", bus.busy, 1'b0);
    tick(3);
    chk("t8_dones", n_done, 0);

    // asynchronous reset mid-STREAM
    clear_log();
    start_job(1, 0, 0);
    tick(5);
    #2 rstn = 1'b0;
    #1 chk_quiet("t9_async_rst");
    tick();
    rstn = 1'b1;
    tick(2);
    chk("t9_dones", n_done, 0);

    // recovery after reset
    clear_log();
    start_job(1, 32, 48);
    wait_idle(200);
    chk("t10_done_n", done_n, 36);
    if (res_log.size() > 7) chk("t10_res7", res_log[7], 55);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vec_mul_tile_ctrl.md
# vec_mul_tile_ctrl

On-chip sequencer for the vector-multiplier datapath. It replaces bench-driven sequencing of weight pop, weight reload, activation streaming and result write-back with an FSM that processes `num_tiles` consecutive MATRIX_SIZE-row tiles per `start`. It sits between the host/bus and the `TOP_vec_mul` datapath control pins, and is parametrised in matrix size, PE rows, drain depth and tile count.

## Interface
- `ADDRESSSIZE`, 10: width of the activation and result SRAM addresses.
- `MATRIX_SIZE`, 8: rows streamed per tile; also the number of result rows written per tile.
- `NUM_PE_ROWS`, 8: PE array depth; only used for the DRAIN_CYCLES default.
- `DRAIN_CYCLES`, MATRIX_SIZE+NUM_PE_ROWS: cycles waited after the last activation before write-back.
- `TILE_W`, 4: width of `num_tiles` (up to 15 tiles per job).
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  job request; honoured only in IDLE.
- `abort`  in  1  synchronous kill; returns the FSM to IDLE.
- `num_tiles`  in  TILE_W  tile count; sampled when `start` is accepted.
- `act_base`  in  ADDRESSSIZE  activation base address; sampled when `start` is accepted.
- `res_base`  in  ADDRESSSIZE  result base address; sampled when `start` is accepted.
- `fifo_empty`  in  1  weight FIFO empty flag.
- `fifo_read_enable`  out  1  weight FIFO pop strobe.
- `weight_reload`  out  1  load the popped weights into the PEs.
- `sram_address`  out  ADDRESSSIZE  activation read address.
- `valid_address`  out  1  qualifies `sram_address`.
- `res_write_enable`  out  1  result SRAM write strobe.
- `res_address`  out  ADDRESSSIZE  result write address.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE inclusive.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Moore FSM. All outputs are decoded from registered state and counters. Every output resets to 0.
- States and per-state behaviour:
  - IDLE. If `start` is sampled and `abort` is low: latch `num_tiles`, `act_base`, `res_base`; clear tile index t and row counter k. Go to DONE if num_tiles==0, else WAIT.
  - WAIT. Hold while `fifo_empty`=1. When `fifo_empty`=0, go to POP.
  - POP. `fifo_read_enable`=1 for exactly one cycle, then go to WRL.
  - WRL. `weight_reload`=1 for exactly one cycle, then go to STREAM.
  - STREAM. Lasts MATRIX_SIZE cycles, k=0..M-1. `valid_address`=1 and `sram_address`=act_base+t*M+k.
  - DRAIN. Lasts DRAIN_CYCLES cycles; all strobes are low.
  - WB. Lasts M cycles. `res_write_enable`=1 and `res_address`=res_base+t*M+k. At the end of WB: if t+1<num_tiles, increment t and go to WAIT; otherwise go to DONE.
  - DONE. `done`=1 and `busy`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDRESSSIZE and wraps silently. The t*M product is computed at ADDRESSSIZE width.
- `start` in any non-IDLE state is ignored; it is not queued.
- `abort` in any state forces IDLE on the next edge:
  - All strobes drop, `busy` drops, and no `done` is issued.
  - `abort` and `start` in the same IDLE cycle: `abort` wins.
- An underflowing FIFO is never popped: POP is reachable only with `fifo_empty`=0.
- Reset mid-job returns the FSM to IDLE immediately and asynchronously.

## Timing
- `start` is accepted at edge E0. State at cycle E0+n, defaults with a non-empty FIFO and one tile:
  - n=1 WAIT, n=2 POP, n=3 WRL.
  - n=4..11 STREAM, n=12..27 DRAIN, n=28..35 WB.
  - n=36 DONE, n=37 IDLE.
- Per-tile cost: 3 + 2M + DRAIN_CYCLES cycles plus FIFO stall cycles. The next `start` can be accepted at n=37.
- `weight_reload` always follows the `fifo_read_enable` cycle by exactly one cycle.

## Configuration
- `VEC_MUL_CTRL_PERF_EN` defined: adds output `stall_cnt` [15:0].
  - Counts cycles spent in WAIT with `fifo_empty`=1 and saturates at 16'hFFFF.
  - Cleared when `start` is accepted; holds its value in IDLE.
  - Reset value 0.
- Not defined: no port, no counter; behaviour is otherwise identical.

## Structure
- Shared package `vec_mul_pkg` holds:
  - the state enum (IDLE, WAIT, POP, WRL, STREAM, DRAIN, WB, DONE);
  - default parameter constants for M, NUM_PE_ROWS and ADDRESSSIZE, reused by `TOP_vec_mul`.
- One sub-module, `vec_mul_addr_gen`: computes base+t*M+k for both address outputs.
- The FSM and counters stay in the top of this block.

## Test plan
- Defaults, num_tiles=1, act_base=0, res_base=0, FIFO non-empty:
  - POP at n=2, WRL at n=3;
  - `sram_address` 0..7 with `valid_address` at n=4..11;
  - writes to 0..7 at n=28..35;
  - `done` at n=36.
- num_tiles=3, act_base=16, res_base=100:
  - activations 16..39 and results 100..123 in order;
  - three POP/WRL pairs;
  - one `done`.
- `fifo_empty` held high for 5 cycles in WAIT:
  - no pop during the hold; POP comes 1 cycle after `fifo_empty` falls;
  - `done` slips by 5 cycles;
  - `stall_cnt`=5 with `VEC_MUL_CTRL_PERF_EN`.
- act_base=1020, one tile: `sram_address` sequence 1020,1021,1022,1023,0,1,2,3.
- `abort` pulsed at n=15 (DRAIN): IDLE at n=16, all outputs 0, no `done`. A `start` 2 cycles later runs a full job normally.
- Edge cases:
  - num_tiles=0: `done` at n=1 with no FIFO or SRAM strobes.
  - `start` while busy: ignored.
  - `rstn` low mid-STREAM: all outputs 0 asynchronously.
